// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer
// Computes WIDTH-bit A+B+c_in (and optionally A-B) by reusing one 4-bit
// carry-lookahead cell, one nibble per clock, least-significant nibble first.
// Valid/ready handshakes on the operand side and on the result side.
//
// Optional feature macro: CLA_SEQ_SUB_EN
//   defined   -> op_sub port exists; op_sub=1 at accept computes A-B
//                (B is inverted and the carry seed forced to 1).
//   undefined -> op_sub port absent; only A+B+c_in is computed.
module cla_word_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // holds the effective B (inverted for subtract)
    logic             carry_q, carry_d;
    logic [WIDTH-5:0] part_q, part_d;    // upper partial result, filled from the top
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_nib;
    logic [WIDTH-1:0] b_eff;
    logic             seed;

    // ------------------------------------------------------------------
    // 4-bit carry-lookahead cell
    // ------------------------------------------------------------------
    logic [3:0] cell_p, cell_g, cell_sum;
    logic [4:0] cell_c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pg
            assign cell_p[gi] = a_q[gi] ^ b_q[gi];
            assign cell_g[gi] = a_q[gi] & b_q[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_sum
            assign cell_sum[gi] = cell_p[gi] ^ cell_c[gi];
        end
    endgenerate

    // Lookahead carries: every carry is a flat sum of products of p/g and
    // the cell carry-in, never a ripple through the previous carry.
    always_comb begin
        logic prod;
        cell_c    = '0;
        cell_c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            cell_c[i+1] = cell_g[i];
            prod        = cell_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cell_c[i+1] = cell_c[i+1] | (prod & cell_g[j]);
                prod        = prod & cell_p[j];
            end
            cell_c[i+1] = cell_c[i+1] | (prod & carry_q);
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign accept   = in_valid && (state_q == S_IDLE);
    assign last_nib = (cnt_q == CW'(NIB - 1));

    // Select the B value and carry seed that the cell will actually see.
    always_comb begin
        b_eff = b;
        seed  = c_in;
`ifdef CLA_SEQ_SUB_EN
        if (op_sub) begin
            b_eff = ~b;
            seed  = 1'b1;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_RUN;
            S_RUN:   if (last_nib)  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: both handshake flags decode the registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] part_full;
    assign part_full = {cell_sum, part_q};

    // Operand capture on accept; nibble step, shifts and result latch in RUN.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = seed;
                    cnt_d   = '0;
                    part_d  = '0;
                end
            end
            S_RUN: begin
                a_d     = {4'b0000, a_q[WIDTH-1:4]};
                b_d     = {4'b0000, b_q[WIDTH-1:4]};
                carry_d = cell_c[4];
                cnt_d   = cnt_q + CW'(1);
                part_d  = part_full[WIDTH-1:4];
                if (last_nib) begin
                    // On the final nibble a_q[3]/b_q[3] are the operand MSBs.
                    cnt_d   = '0;
                    sum_d   = part_full;
                    c_out_d = cell_c[4];
                    ovf_d   = (a_q[3] == b_q[3]) && (cell_sum[3] != a_q[3]);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an aborted operation leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer (WIDTH=16).
// Reference model: plain integer addition of A, effective B and the carry seed.
module tb_cla_word_sequencer;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    cla_word_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef CLA_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {overflow, carry, sum} of a + b_eff + seed.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         seed;
        logic         ov;
        beff = msub ? ~mb : mb;
        seed = msub ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, seed};
        ov   = (ma[W-1] == beff[W-1]) && (full[W-1] != ma[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    // Stimulus driver: accept one operation, scramble inputs, wait for out_valid.
    // Returns in the first DONE cycle (#1 after the edge); lat=-1 on timeout.
    int           obs_lat;
    int           obs_accept_cyc;
    bit           obs_busy_ok;
    logic [W-1:0] obs_sum;
    logic         obs_c, obs_ovf;

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts);
        in_valid = 1'b1;
        a = ta; b = tb_; c_in = tc; op_sub = ts;
        @(posedge clk);
        #1;
        obs_accept_cyc = cyc;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); op_sub = 1'($urandom);
        obs_lat = 0;
        obs_busy_ok = 1'b1;
        while (out_valid !== 1'b1 && obs_lat < 20) begin
            if (in_ready !== 1'b0) obs_busy_ok = 1'b0;
            @(posedge clk);
            #1;
            obs_lat++;
        end
        if (out_valid !== 1'b1) obs_lat = -1;
        if (in_ready !== 1'b0) obs_busy_ok = 1'b0;
        obs_sum = sum; obs_c = c_out; obs_ovf = overflow;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if ({c_out, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {c_out, overflow}); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add_directed();
        logic [W-1:0] va [3] = '{16'h00FF, 16'hFFFF, 16'h7FFF};
        logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h0001};
        logic [W-1:0] vs [3] = '{16'h0100, 16'h0000, 16'h8000};
        logic         vc [3] = '{1'b0, 1'b1, 1'b0};
        logic         vo [3] = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, 1'b0);
            $display("add a=%h b=%h -> sum=%h c=%b ovf=%b lat=%0d", va[i], vb[i], obs_sum, obs_c, obs_ovf, obs_lat);
            checks++; if (obs_lat != NIB) begin errors++; $display("FAIL add_latency[%0d]: got %0d expected %0d", i, obs_lat, NIB); end
            checks++; if (!obs_busy_ok) begin errors++; $display("FAIL add_busy[%0d]: in_ready got 1 expected 0", i); end
            checks++; if (obs_sum !== vs[i]) begin errors++; $display("FAIL add_sum[%0d]: got %h expected %h", i, obs_sum, vs[i]); end
            checks++; if (obs_c !== vc[i]) begin errors++; $display("FAIL add_cout[%0d]: got %b expected %b", i, obs_c, vc[i]); end
            checks++; if (obs_ovf !== vo[i]) begin errors++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, obs_ovf, vo[i]); end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run_op(16'h1234, 16'h1111, 1'b1, 1'b0);
        checks++; if (obs_sum !== 16'h2346) begin errors++; $display("FAIL bp_sum: got %h expected 2346", obs_sum); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (!(out_valid === 1'b1 && in_ready === 1'b0 && sum === 16'h2346))
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%b r=%b s=%h expected v=1 r=0 s=2346", k, out_valid, in_ready, sum); end
            if (k == 3) out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin errors++; $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
        checks++; if (sum !== 16'h2346) begin errors++; $display("FAIL bp_idle_hold: got %h expected 2346", sum); end
        $display("backpressure sum=%h", obs_sum);
    endtask

    task automatic test_reset_abort();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'hABCD; b = 16'h5678; c_in = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (!(out_valid === 1'b0 && in_ready === 1'b1 && sum === 16'h0000 && c_out === 1'b0 && overflow === 1'b0))
            begin errors++; $display("FAIL abort_reset: got v=%b r=%b s=%h c=%b o=%b expected 0 1 0000 0 0", out_valid, in_ready, sum, c_out, overflow); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0);
        $display("after abort sum=%h lat=%0d", obs_sum, obs_lat);
        checks++; if (obs_lat != NIB) begin errors++; $display("FAIL abort_latency: got %0d expected %0d", obs_lat, NIB); end
        checks++; if ({obs_ovf, obs_c, obs_sum} !== {2'b00, 16'h0007}) begin errors++; $display("FAIL abort_sum: got %h expected 00007", {obs_ovf, obs_c, obs_sum}); end
        handoff();
    endtask

`ifdef CLA_SEQ_SUB_EN
    task automatic test_sub_directed();
        out_ready = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        $display("sub 0005-0007 -> sum=%h c=%b ovf=%b", obs_sum, obs_c, obs_ovf);
        checks++; if ({obs_ovf, obs_c, obs_sum} !== {2'b00, 16'hFFFE}) begin errors++; $display("FAIL sub_a: got %h expected 0FFFE", {obs_ovf, obs_c, obs_sum}); end
        handoff();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        $display("sub 8000-0001 -> sum=%h c=%b ovf=%b", obs_sum, obs_c, obs_ovf);
        checks++; if ({obs_ovf, obs_c, obs_sum} !== {2'b11, 16'h7FFF}) begin errors++; $display("FAIL sub_b: got %h expected 37FFF", {obs_ovf, obs_c, obs_sum}); end
        handoff();
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        logic [W+1:0] exp_v;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (n == 0) begin ra = 16'h8000; rb = 16'h8000; end
            if (n == 1) begin ra = 16'h0000; rb = 16'h0000; end
            exp_v = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs);
            $display("rand %0d a=%h b=%h c=%b sub=%b -> %h exp %h", n, ra, rb, rc, rs, {obs_ovf, obs_c, obs_sum}, exp_v);
            checks++; if ({obs_ovf, obs_c, obs_sum} !== exp_v) begin errors++; $display("FAIL rand_result[%0d]: got %h expected %h", n, {obs_ovf, obs_c, obs_sum}, exp_v); end
            checks++; if (obs_lat != NIB) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, obs_lat, NIB); end
            handoff();
        end
    endtask

    task automatic test_back_to_back();
        int prev_acc;
        logic [W-1:0] ra, rb;
        logic [W+1:0] exp_v;
        out_ready = 1'b1;
        prev_acc = -1;
        for (int n = 0; n < 4; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            exp_v = model(ra, rb, 1'b0, 1'b0);
            run_op(ra, rb, 1'b0, 1'b0);
            $display("b2b %0d accept_cycle=%0d result=%h", n, obs_accept_cyc, {obs_ovf, obs_c, obs_sum});
            checks++; if ({obs_ovf, obs_c, obs_sum} !== exp_v) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", n, {obs_ovf, obs_c, obs_sum}, exp_v); end
            if (prev_acc >= 0) begin
                checks++; if (obs_accept_cyc - prev_acc != NIB + 2) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", n, obs_accept_cyc - prev_acc, NIB + 2); end
            end
            prev_acc = obs_accept_cyc;
            handoff();
        end
    endtask

    initial begin
        test_reset();
        test_add_directed();
        test_backpressure();
        test_reset_abort();
`ifdef CLA_SEQ_SUB_EN
        test_sub_directed();
`endif
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
